// File: rtl/tilemap_addr_gen.sv
// Tilemap address generator: per-layer scroll/flip tile fetches time-multiplexed
// with acknowledged CPU tile-RAM accesses in the spare slots of each 8-pixel group.
module tilemap_addr_gen #(
  parameter int LAYERS    = 2,
  parameter int COLS_LOG2 = 6,
  parameter int ROWS_LOG2 = 5,
  parameter int SX_W      = 9,
  parameter int SY_W      = 8,
  parameter int CA_W      = 14,
  parameter int GA_W      = 14,
  localparam int LB       = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
  input  logic            CLK_6M,
  input  logic            RST_N,
  input  logic            PIX_EN,
  input  logic            HSYNC,
  input  logic            VSYNC,
  input  logic            FLIP,
  input  logic            LATCH,
  input  logic            RCS,
  input  logic            WE,
  input  logic [CA_W-1:0] CA,
  input  logic [7:0]      CD,
  output logic [GA_W-1:0] GA,
  output logic [LB-1:0]   GA_LAYER,
  output logic            GA_VALID,
  output logic            RWE,
  output logic            ROE,
  output logic [7:0]      RD,
  output logic            CPU_ACK
);

  logic [SX_W-1:0] hCnt_q, hCnt_d;
  logic [SY_W-1:0] vCnt_q, vCnt_d;
  logic            hsPrev_q, vsPrev_q, rcsPrev_q;
  logic            flip_q, flip_d;
  logic            pending_q, pending_d;
  logic [SX_W-1:0] sxShadow_q [LAYERS];
  logic [SX_W-1:0] sxShadow_d [LAYERS];
  logic [SX_W-1:0] sxLive_q   [LAYERS];
  logic [SX_W-1:0] sxLive_d   [LAYERS];
  logic [SY_W-1:0] syShadow_q [LAYERS];
  logic [SY_W-1:0] syShadow_d [LAYERS];
  logic [SY_W-1:0] syLive_q   [LAYERS];
  logic [SY_W-1:0] syLive_d   [LAYERS];
  logic [GA_W-1:0] ga_q, ga_d;
  logic [LB-1:0]   gaLayer_q, gaLayer_d;
  logic            gaValid_q, gaValid_d;
  logic            rwe_q, rwe_d, roe_q, roe_d, ack_q, ack_d;
  logic [7:0]      rd_q, rd_d;

  logic            hsRise, vsRise, rcsRise, scrollWr, isFetch;
  logic [2:0]      slot;
  logic [LB-1:0]   fetchLayer, wrLayer;
  logic [SX_W-1:0] sxSel, xPos;
  logic [SY_W-1:0] sySel, yPos;
  logic            unusedBits;

  always_comb begin
    hsRise     = HSYNC & ~hsPrev_q;
    vsRise     = VSYNC & ~vsPrev_q;
    rcsRise    = RCS & ~rcsPrev_q;
    slot       = hCnt_q[2:0];
    fetchLayer = slot[LB-1:0];
    isFetch    = (slot < 3'(LAYERS));
    sxSel      = '0;
    sySel      = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (slot == 3'(i)) begin
        sxSel = sxLive_q[i];
        sySel = syLive_q[i];
      end
    end
    // Look one tile ahead so the fetched tile is ready when its pixels start.
    xPos = hCnt_q + sxSel + SX_W'(8);
    yPos = vCnt_q + sySel;
    if (flip_q) begin
      xPos = ~xPos;
      yPos = ~yPos;
    end
    unusedBits = ^{xPos[2:0], yPos[2:0]};

    hCnt_d   = hsRise ? '0 : (PIX_EN ? hCnt_q + SX_W'(1) : hCnt_q);
    vCnt_d   = vsRise ? '0 : (hsRise ? vCnt_q + SY_W'(1) : vCnt_q);
    flip_d   = hsRise ? FLIP : flip_q;
    scrollWr = LATCH & WE;
    wrLayer  = CA[LB+1:2];
    for (int i = 0; i < LAYERS; i++) begin
      sxShadow_d[i] = sxShadow_q[i];
      syShadow_d[i] = syShadow_q[i];
      if (scrollWr && wrLayer == LB'(i)) begin
        case (CA[1:0])
          2'd0:    sxShadow_d[i][7:0] = CD;
          2'd1:    sxShadow_d[i][SX_W-1:8] = CD[SX_W-9:0];
          2'd2:    syShadow_d[i] = SY_W'(CD);
          default: ;
        endcase
      end
      // Live takes the shadow including any write landing in the same cycle.
      sxLive_d[i] = hsRise ? sxShadow_d[i] : sxLive_q[i];
      syLive_d[i] = hsRise ? syShadow_d[i] : syLive_q[i];
    end

    ga_d      = ga_q;
    gaLayer_d = gaLayer_q;
    rd_d      = rd_q;
    gaValid_d = 1'b0;
    rwe_d     = 1'b0;
    roe_d     = 1'b0;
    ack_d     = 1'b0;
    pending_d = pending_q;
    if (isFetch) begin
      ga_d      = GA_W'({fetchLayer, yPos[ROWS_LOG2+2:3], xPos[COLS_LOG2+2:3]});
      gaLayer_d = fetchLayer;
      gaValid_d = 1'b1;
      roe_d     = 1'b1;
    end else if (pending_q) begin
      ga_d      = GA_W'(CA);
      rwe_d     = WE;
      roe_d     = ~WE;
      rd_d      = CD;
      ack_d     = 1'b1;
      pending_d = 1'b0;
    end
    if (rcsRise) pending_d = 1'b1;
  end

  // Edge detectors keep tracking during reset so a level already high at release is no new edge.
  always_ff @(posedge CLK_6M) begin
    hsPrev_q  <= HSYNC;
    vsPrev_q  <= VSYNC;
    rcsPrev_q <= RCS;
    if (!RST_N) begin
      hCnt_q    <= '0;
      vCnt_q    <= '0;
      flip_q    <= 1'b0;
      pending_q <= 1'b0;
      for (int i = 0; i < LAYERS; i++) begin
        sxShadow_q[i] <= '0;
        sxLive_q[i]   <= '0;
        syShadow_q[i] <= '0;
        syLive_q[i]   <= '0;
      end
      ga_q      <= '0;
      gaLayer_q <= '0;
      gaValid_q <= 1'b0;
      rwe_q     <= 1'b0;
      roe_q     <= 1'b0;
      rd_q      <= '0;
      ack_q     <= 1'b0;
    end else begin
      hCnt_q    <= hCnt_d;
      vCnt_q    <= vCnt_d;
      flip_q    <= flip_d;
      pending_q <= pending_d;
      for (int i = 0; i < LAYERS; i++) begin
        sxShadow_q[i] <= sxShadow_d[i];
        sxLive_q[i]   <= sxLive_d[i];
        syShadow_q[i] <= syShadow_d[i];
        syLive_q[i]   <= syLive_d[i];
      end
      ga_q      <= ga_d;
      gaLayer_q <= gaLayer_d;
      gaValid_q <= gaValid_d;
      rwe_q     <= rwe_d;
      roe_q     <= roe_d;
      rd_q      <= rd_d;
      ack_q     <= ack_d;
    end
  end

  assign GA       = ga_q;
  assign GA_LAYER = gaLayer_q;
  assign GA_VALID = gaValid_q;
  assign RWE      = rwe_q;
  assign ROE      = roe_q;
  assign RD       = rd_q;
  assign CPU_ACK  = ack_q;

endmodule

// File: tb/tb_tilemap_addr_gen.sv
// Bench for tilemap_addr_gen: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_tilemap_addr_gen;

  localparam int LAYERS    = 2;
  localparam int COLS_LOG2 = 6;
  localparam int ROWS_LOG2 = 5;
  localparam int SX_W      = 9;
  localparam int SY_W      = 8;
  localparam int CA_W      = 14;
  localparam int GA_W      = 14;
  localparam int LB_TB     = 1;

  logic            CLK_6M, RST_N, PIX_EN, HSYNC, VSYNC, FLIP, LATCH, RCS, WE;
  logic [CA_W-1:0] CA;
  logic [7:0]      CD;
  logic [GA_W-1:0] GA;
  logic [LB_TB-1:0] GA_LAYER;
  logic            GA_VALID, RWE, ROE, CPU_ACK;
  logic [7:0]      RD;

  int compared = 0;
  int mismatched = 0;

  tilemap_addr_gen #(
    .LAYERS(LAYERS), .COLS_LOG2(COLS_LOG2), .ROWS_LOG2(ROWS_LOG2),
    .SX_W(SX_W), .SY_W(SY_W), .CA_W(CA_W), .GA_W(GA_W)
  ) dut (
    .CLK_6M(CLK_6M), .RST_N(RST_N), .PIX_EN(PIX_EN), .HSYNC(HSYNC),
    .VSYNC(VSYNC), .FLIP(FLIP), .LATCH(LATCH), .RCS(RCS), .WE(WE),
    .CA(CA), .CD(CD), .GA(GA), .GA_LAYER(GA_LAYER), .GA_VALID(GA_VALID),
    .RWE(RWE), .ROE(ROE), .RD(RD), .CPU_ACK(CPU_ACK)
  );

  initial begin
    CLK_6M = 1'b0;
    forever #5 CLK_6M = ~CLK_6M;
  end

  // Reference model: counters, scroll registers and slot rules as plain integers.
  int mH, mV, slot, x, y, wl;
  int mSx[4], mSy[4], mShx[4], mShy[4];
  bit mFlip, mPend, pH, pV, pR, hr, vr, rr;
  int eGa, eLayer, eRd;
  bit eValid, eRwe, eRoe, eAck;

  always @(posedge CLK_6M) begin
    if (!RST_N) begin
      mH = 0; mV = 0; mFlip = 0; mPend = 0;
      for (int i = 0; i < 4; i++) begin
        mSx[i] = 0; mSy[i] = 0; mShx[i] = 0; mShy[i] = 0;
      end
      eGa = 0; eLayer = 0; eRd = 0;
      eValid = 0; eRwe = 0; eRoe = 0; eAck = 0;
    end else begin
      hr = HSYNC && !pH;
      vr = VSYNC && !pV;
      rr = RCS && !pR;
      slot = mH % 8;
      if (slot < LAYERS) begin
        x = (mH + mSx[slot] + 8) % (1 << SX_W);
        y = (mV + mSy[slot]) % (1 << SY_W);
        if (mFlip) begin
          x = (1 << SX_W) - 1 - x;
          y = (1 << SY_W) - 1 - y;
        end
        eGa = slot * (1 << (ROWS_LOG2 + COLS_LOG2))
            + ((y / 8) % (1 << ROWS_LOG2)) * (1 << COLS_LOG2)
            + (x / 8) % (1 << COLS_LOG2);
        eLayer = slot; eValid = 1; eRoe = 1; eRwe = 0; eAck = 0;
      end else if (mPend) begin
        eGa = int'(CA) % (1 << GA_W);
        eValid = 0; eRwe = WE; eRoe = !WE; eRd = CD; eAck = 1;
        mPend = 0;
      end else begin
        eValid = 0; eRwe = 0; eRoe = 0; eAck = 0;
      end
      if (rr) mPend = 1;
      if (LATCH && WE) begin
        wl = (int'(CA) >> 2) % (1 << LB_TB);
        if (wl < LAYERS) begin
          case (int'(CA) % 4)
            0: mShx[wl] = (mShx[wl] / 256) * 256 + CD;
            1: mShx[wl] = (CD % (1 << (SX_W - 8))) * 256 + mShx[wl] % 256;
            2: mShy[wl] = CD % (1 << SY_W);
            default: ;
          endcase
        end
      end
      if (hr) begin
        for (int i = 0; i < 4; i++) begin
          mSx[i] = mShx[i];
          mSy[i] = mShy[i];
        end
        mFlip = FLIP;
      end
      if (hr) mH = 0;
      else if (PIX_EN) mH = (mH + 1) % (1 << SX_W);
      if (vr) mV = 0;
      else if (hr) mV = (mV + 1) % (1 << SY_W);
    end
    pH = HSYNC; pV = VSYNC; pR = RCS;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge CLK_6M) begin
    checkOutput("GA", int'(GA), eGa);
    checkOutput("GA_VALID", int'(GA_VALID), int'(eValid));
    checkOutput("ROE", int'(ROE), int'(eRoe));
    checkOutput("RWE", int'(RWE), int'(eRwe));
    checkOutput("CPU_ACK", int'(CPU_ACK), int'(eAck));
    if (eValid) checkOutput("GA_LAYER", int'(GA_LAYER), eLayer);
    if (eAck) checkOutput("RD", int'(RD), eRd);
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK_6M);
  endtask

  task automatic hsPulse();
    HSYNC = 1'b1;
    step(1);
    HSYNC = 1'b0;
    step(1);
  endtask

  task automatic scrollWrite(input int layer, input int regSel, input int val);
    LATCH = 1'b1; WE = 1'b1;
    CA = 14'(layer * 4 + regSel);
    CD = 8'(val);
    step(1);
    LATCH = 1'b0; WE = 1'b0;
  endtask

  task automatic applyStimulus();
    PIX_EN = ($urandom_range(0, 3) != 0);
    HSYNC  = ($urandom_range(0, 39) < 2);
    VSYNC  = ($urandom_range(0, 299) == 0);
    if ($urandom_range(0, 99) == 0) FLIP = !FLIP;
    LATCH  = ($urandom_range(0, 9) == 0);
    if (RCS) RCS = ($urandom_range(0, 11) != 0);
    else     RCS = ($urandom_range(0, 5) == 0);
    WE     = 1'($urandom_range(0, 1));
    CA     = 14'($urandom_range(0, 16383));
    CD     = 8'($urandom_range(0, 255));
    RST_N  = ($urandom_range(0, 599) != 0);
    step(1);
  endtask

  int ackCnt, capGa, capRwe, capRoe, capRd;

  initial begin
    RST_N = 1'b0; PIX_EN = 1'b0; HSYNC = 1'b0; VSYNC = 1'b0; FLIP = 1'b0;
    LATCH = 1'b0; RCS = 1'b0; WE = 1'b0; CA = '0; CD = '0;
    step(3);
    checkOutput("rst_GA", int'(GA), 0);
    checkOutput("rst_valid", int'(GA_VALID), 0);
    checkOutput("rst_ack", int'(CPU_ACK), 0);
    RST_N = 1'b1;

    $display("[TB] basic fetch at VCNT=16");
    repeat (16) hsPulse();
    step(2);
    checkOutput("t1_GA", int'(GA), 129);
    checkOutput("t1_model", eGa, 129);
    checkOutput("t1_valid", int'(GA_VALID), 1);
    checkOutput("t1_layer", int'(GA_LAYER), 0);

    $display("[TB] column wrap and flip on layer 1");
    scrollWrite(1, 0, 8'hF8);
    scrollWrite(1, 1, 8'h01);
    hsPulse();
    PIX_EN = 1'b1; step(1); PIX_EN = 1'b0;
    step(2);
    checkOutput("t2_GA", int'(GA), 2176);
    checkOutput("t2_model", eGa, 2176);
    checkOutput("t2_layer", int'(GA_LAYER), 1);
    FLIP = 1'b1;
    hsPulse();
    FLIP = 1'b0;
    PIX_EN = 1'b1; step(1); PIX_EN = 1'b0;
    step(2);
    checkOutput("t2_flipGA", int'(GA), 3967);
    checkOutput("t2_flipModel", eGa, 3967);

    $display("[TB] shadow scroll timing");
    hsPulse();
    scrollWrite(0, 0, 8'h10);
    step(2);
    checkOutput("t3_hold", int'(GA), 129);
    LATCH = 1'b1; WE = 1'b1; CA = 14'd0; CD = 8'hF8; HSYNC = 1'b1;
    step(1);
    LATCH = 1'b0; WE = 1'b0; HSYNC = 1'b0;
    step(2);
    checkOutput("t3_sameCycle", int'(GA), 160);
    checkOutput("t3_model", eGa, 160);

    $display("[TB] CPU write with RCS held");
    PIX_EN = 1'b1; RCS = 1'b1; WE = 1'b1; CA = 14'h1234; CD = 8'hA5;
    ackCnt = 0; capGa = 0; capRwe = 0; capRoe = 1; capRd = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (CPU_ACK) begin
        ackCnt++;
        capGa = int'(GA); capRwe = int'(RWE); capRoe = int'(ROE); capRd = int'(RD);
      end
    end
    RCS = 1'b0; WE = 1'b0;
    checkOutput("t4_ackCount", ackCnt, 1);
    checkOutput("t4_GA", capGa, 16'h1234);
    checkOutput("t4_RWE", capRwe, 1);
    checkOutput("t4_ROE", capRoe, 0);
    checkOutput("t4_RD", capRd, 8'hA5);

    $display("[TB] reset drops pending read");
    PIX_EN = 1'b0;
    hsPulse();
    RCS = 1'b1; WE = 1'b0; CA = 14'h0ABC;
    step(2);
    RST_N = 1'b0;
    step(2);
    checkOutput("t5_rstGA", int'(GA), 0);
    checkOutput("t5_rstROE", int'(ROE), 0);
    RST_N = 1'b1; PIX_EN = 1'b1;
    ackCnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (CPU_ACK) ackCnt++;
    end
    checkOutput("t5_noAck", ackCnt, 0);
    RCS = 1'b0; step(1); RCS = 1'b1;
    ackCnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (CPU_ACK) ackCnt++;
    end
    checkOutput("t5_reRise", ackCnt, 1);
    RCS = 1'b0;

    $display("[TB] VSYNC and HSYNC together");
    repeat (12) hsPulse();
    step(5);
    PIX_EN = 1'b0; HSYNC = 1'b1; VSYNC = 1'b1;
    step(1);
    HSYNC = 1'b0; VSYNC = 1'b0;
    step(2);
    checkOutput("t6_GA", int'(GA), 1);
    checkOutput("t6_valid", int'(GA_VALID), 1);

    $display("[TB] randomized traffic");
    RST_N = 1'b0; step(2); RST_N = 1'b1;
    for (int i = 0; i < 4000; i++) applyStimulus();
    RST_N = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
